// File: rtl/serial_pattern_ctrl.sv
// Word-to-serial controller: scans an accepted word MSB-first through a Mealy
// pattern recogniser and returns match count, hit flag and last match position.
module serial_pattern_ctrl #(
    parameter int W = 8,
    parameter int PLEN = 3,
    parameter logic [PLEN-1:0] PATTERN = 3'b101,
    parameter int CNT_W = 4,
    parameter int POS_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_keep_hist,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit,
    output logic [POS_W-1:0] out_last_pos,
    output logic             busy,
    output logic             bit_x,
    output logic             bit_z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [POS_W-1:0] FILL_MAX = POS_W'(PLEN - 1);
    localparam logic [POS_W-1:0] IDX_LAST = POS_W'(W - 1);

    state_t            state_r;
    logic [W-1:0]      shreg_r;
    logic [POS_W-1:0]  idx_r;
    logic [POS_W-1:0]  fill_r;
    logic [PLEN-2:0]   hist_r;
    logic [PLEN-1:0]   cand_s;

    // Serial bit and Mealy match output; the shift register is left-shifted so
    // its MSB is always the bit at position idx.
    always_comb begin
        bit_x  = 1'b0;
        cand_s = {hist_r, 1'b0};
        bit_z  = 1'b0;
        if (state_r == SHIFT) begin
            bit_x  = shreg_r[W-1];
            cand_s = {hist_r, shreg_r[W-1]};
            bit_z  = (fill_r == FILL_MAX) && (cand_s == PATTERN);
        end else begin
            bit_x  = 1'b0;
            cand_s = {hist_r, 1'b0};
            bit_z  = 1'b0;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            shreg_r      <= {W{1'b0}};
            idx_r        <= {POS_W{1'b0}};
            fill_r       <= {POS_W{1'b0}};
            hist_r       <= {(PLEN-1){1'b0}};
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_count    <= {CNT_W{1'b0}};
            out_hit      <= 1'b0;
            out_last_pos <= {POS_W{1'b0}};
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shreg_r      <= in_data;
                        idx_r        <= {POS_W{1'b0}};
                        out_count    <= {CNT_W{1'b0}};
                        out_hit      <= 1'b0;
                        out_last_pos <= {POS_W{1'b0}};
                        if (!in_keep_hist) begin
                            hist_r <= {(PLEN-1){1'b0}};
                            fill_r <= {POS_W{1'b0}};
                        end
                        state_r  <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    hist_r  <= cand_s[PLEN-2:0];
                    shreg_r <= {shreg_r[W-2:0], 1'b0};
                    idx_r   <= idx_r + POS_W'(1);
                    if (fill_r != FILL_MAX) begin
                        fill_r <= fill_r + POS_W'(1);
                    end
                    if (bit_z) begin
                        out_count    <= out_count + CNT_W'(1);
                        out_hit      <= 1'b1;
                        out_last_pos <= idx_r;
                    end
                    if (idx_r == IDX_LAST) begin
                        state_r   <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_pattern_ctrl.md
Name: serial_pattern_ctrl

Overview:
Controller that sequences a serial Mealy pattern detector over parallel input words.
- Accepts a W-bit word over a valid/ready handshake.
- Shifts the word MSB-first, one bit per clock, through an embedded Mealy recogniser.
- Counts overlapping pattern matches and returns a result record over a second valid/ready handshake.
- Sits between a word-oriented producer and the bit-serial detection logic; the serial bit and Mealy output are exported for monitoring.

Parameters:
- W, 8, input word width in bits (W >= 2).
- PLEN, 3, pattern length in bits (2 <= PLEN <= W).
- PATTERN, 3'b101, pattern to detect, PLEN bits; the MSB is the earliest bit in time.
- CNT_W, 4, match-count width; must satisfy 2**CNT_W > W.
- POS_W, 3, bit-position width; must satisfy 2**POS_W >= W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  W  word to scan, bit W-1 first.
- in_keep_hist  in  1  1 = keep detector history from the previous word; sampled with in_data.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CNT_W  number of matches in the word.
- out_hit  out  1  at least one match.
- out_last_pos  out  POS_W  index (0 = first bit shifted) of the last match; 0 if none.
- busy  out  1  state != IDLE.
- bit_x  out  1  serial bit currently presented to the detector (0 outside SHIFT).
- bit_z  out  1  Mealy match output, combinational on bit_x.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_count=0, out_hit=0, out_last_pos=0, busy=0, bit_x=0, bit_z=0. The history register and fill counter are both cleared.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: latch in_data into the shift register; idx=0; clear count, hit and last_pos.
  - If in_keep_hist=0, also clear the history register and fill counter.
  - Go to SHIFT.
- SHIFT:
  - bit_x = shreg[W-1-idx].
  - Define cand = {hist[PLEN-2:0], bit_x}.
  - bit_z = (fill==PLEN-1) && (cand==PATTERN). This is a Mealy output: valid in the same cycle as bit_x.
  - Each edge:
    - hist <= cand[PLEN-2:0].
    - fill saturates upward at PLEN-1.
    - If bit_z: count+1 and last_pos<=idx.
    - idx+1.
  - On the edge where idx==W-1, go to HOLD.
  - Overlapping matches are counted.
  - bit_x and bit_z are 0 in IDLE and HOLD.
- HOLD:
  - out_valid=1; out_count, out_hit and out_last_pos are held stable.
  - On out_valid&&out_ready, go to IDLE; out_valid deasserts on the following cycle.
- Latency: out_valid rises exactly W edges after the accepting edge. The minimum word-to-word period is W+2 cycles.
- in_ready=1 only in IDLE. If in_valid is high during SHIFT or HOLD, it is ignored and the data is not consumed.
- Simultaneous out_ready and in_valid in HOLD: the result is consumed, and the new word is accepted no earlier than the next (IDLE) cycle.
- out_ready held low: HOLD persists indefinitely with all outputs stable.
- History carry: hist and fill persist across words through IDLE and HOLD. They are cleared only by reset or by acceptance with in_keep_hist=0.
- Reset mid-operation: the in-flight word is discarded, no result is emitted, and all registers return to their reset values.
- count cannot overflow, given the constraint on CNT_W.

Test Plan:
1. Assert reset_n=0 and release -> in_ready=1, out_valid=0, busy=0, out_count=0, bit_z=0.
2. Send in_data=8'b10101010, keep_hist=0 -> bit_z high at idx 2,4,6; out_valid exactly 8 edges after accept; out_count=3, out_hit=1, out_last_pos=6.
3. Send in_data=8'h00 -> out_count=0, out_hit=0, out_last_pos=0.
4. History carry:
   - Send 8'b00000010 (result count 0), then 8'b10000000 with keep_hist=1 -> count=1, last_pos=0.
   - Repeat with keep_hist=0 -> count=0.
5. Backpressure: hold out_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0 and outputs stable throughout. Then out_ready=1 -> IDLE next cycle; the new word is accepted on the following edge.
6. Reset mid-operation:
   - Send 8'b00000010, then assert reset_n low at idx=3 of the next word -> out_valid=0, in_ready=1, no result emitted.
   - Then send 8'b10000000 with keep_hist=1 -> count=0, because history was cleared.
